// File: rtl/riscv_pkg.sv
// Constants shared by the RV32I fetch front end and control unit: widths, reset PC, NOP and opcodes.
// Pure definitions, no logic, no latency and no backpressure.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RV_NOP   = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_t;

  function automatic opcode_t instr_opcode(input logic [31:0] instr);
    return opcode_t'(instr[6:0]);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with flush; a push is visible at the head one cycle later (no bypass).
// No internal backpressure: the producer must never push while full unless it pops in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count    = count_q;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // flush wins over push so a redirect never lets a stale word through
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: PC, one-deep outstanding imem read, fetch buffer to decode; first word 2 cycles after issue.
// Issue stops when buffered + in-flight words would exceed the buffer; decode stalls via ready_d.
module instr_fetch_unit #(
  parameter int                XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC   = riscv_pkg::RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            valid_d,
  input  logic            ready_d
);
  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  logic [XLEN-1:0] pc_q, req_pc_q, pcd_q;
  logic            outstanding_q, discard_q;
  logic [CW-1:0]   count;
  logic [CW:0]     demand;
  logic            pop, push, grant;
  fetch_entry_t    push_entry, head_entry;

  assign valid_d = !rst && (count != '0);
  assign pop     = valid_d && ready_d;

  // slots already spoken for next cycle: buffered words leaving + the word still in flight
  assign demand    = {1'b0, count} + (CW+1)'(outstanding_q) - (CW+1)'(pop);
  assign imem_req  = !rst && !PCSrcE && (demand < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  assign push       = !rst && imem_rvalid && outstanding_q && !discard_q && !PCSrcE;
  assign push_entry = '{instr: imem_rdata, pc: req_pc_q};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (PCSrcE),
    .count    (count),
    .head_dat (head_entry)
  );

  assign InstrD   = valid_d ? head_entry.instr : RV_NOP;
  assign PCD      = rst ? '0 : (valid_d ? head_entry.pc : pcd_q);
  assign PCPlus4D = PCD + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      pcd_q         <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      if (valid_d) pcd_q <= head_entry.pc;
      discard_q <= 1'b0;
      if (PCSrcE) begin
        pc_q          <= {PCTargetE[XLEN-1:2], 2'b00};
        outstanding_q <= 1'b0;
        discard_q     <= outstanding_q;
      end else if (grant) begin
        pc_q          <= pc_q + XLEN'(4);
        req_pc_q      <= pc_q;
        outstanding_q <= 1'b1;
      end else if (imem_rvalid) begin
        outstanding_q <= 1'b0;
      end
    end
  end

endmodule
